// File: rtl/warp_barrier_unit.sv
// Warp barrier unit: tracks per-barrier arrival masks, stalls arriving warps and
// releases them on local completion or on the cluster response for global barriers.
module warp_barrier_unit #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int NUM_CORES    = 4,
  parameter int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
  parameter int SZ_WIDTH     = (NW_WIDTH > $clog2(NUM_CORES)) ? NW_WIDTH : $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NW_WIDTH-1:0]  req_wid,
  input  logic [NB_WIDTH-1:0]  req_id,
  input  logic                 req_is_global,
  input  logic [SZ_WIDTH-1:0]  req_size_m1,
  input  logic                 req_is_noop,
  input  logic [NUM_WARPS-1:0] active_warps,
  output logic [NUM_WARPS-1:0] stalled_warps,
  output logic                 unlock_valid,
  output logic [NUM_WARPS-1:0] unlock_mask,
  output logic                 gbar_req_valid,
  output logic [NB_WIDTH-1:0]  gbar_req_id,
  output logic [SZ_WIDTH-1:0]  gbar_req_size_m1,
  input  logic                 gbar_req_ready,
  input  logic                 gbar_rsp_valid,
  input  logic [NB_WIDTH-1:0]  gbar_rsp_id,
  output logic                 dup_err
);

  localparam logic [1:0] G_IDLE    = 2'd0;
  localparam logic [1:0] G_COLLECT = 2'd1;
  localparam logic [1:0] G_SENT    = 2'd2;

  logic [NUM_WARPS-1:0] lmask   [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] gmask   [NUM_BARRIERS];
  logic [1:0]           gstate  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] lmask_d [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] gmask_d [NUM_BARRIERS];
  logic [1:0]           gstate_d[NUM_BARRIERS];

  logic                 greq_valid_d;
  logic [NB_WIDTH-1:0]  greq_id_d;
  logic [SZ_WIDTH-1:0]  greq_size_d;
  logic                 unlock_valid_d;
  logic [NUM_WARPS-1:0] unlock_mask_d;
  logic                 dup_d;
  logic [NUM_WARPS-1:0] stalled_d;
  logic [NUM_WARPS-1:0] wid_oh;
  logic [NUM_WARPS-1:0] gmask_new;
  logic                 accept;

  assign req_ready = !gbar_req_valid;
  assign accept    = req_valid && req_ready;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    lmask_d        = lmask;
    gmask_d        = gmask;
    gstate_d       = gstate;
    greq_valid_d   = gbar_req_valid;
    greq_id_d      = gbar_req_id;
    greq_size_d    = gbar_req_size_m1;
    unlock_valid_d = 1'b0;
    unlock_mask_d  = '0;
    dup_d          = 1'b0;
    wid_oh         = NUM_WARPS'(1) << req_wid;
    gmask_new      = gmask[req_id] | wid_oh;

    if (accept && !req_is_noop) begin
      if (!req_is_global) begin
        if (((lmask[req_id] | gmask[req_id]) & wid_oh) != '0) begin
          dup_d = 1'b1;
        end else if ($countones(lmask[req_id]) == 32'(req_size_m1)) begin
          unlock_valid_d   = 1'b1;
          unlock_mask_d    = lmask[req_id] | wid_oh;
          lmask_d[req_id]  = '0;
        end else begin
          lmask_d[req_id]  = lmask[req_id] | wid_oh;
        end
      end else begin
        gmask_d[req_id] = gmask_new;
        if (gstate[req_id] == G_IDLE) gstate_d[req_id] = G_COLLECT;
        // A SENT barrier already has its core-level request in flight.
        if (gstate[req_id] != G_SENT && (gmask_new & active_warps) == active_warps) begin
          greq_valid_d = 1'b1;
          greq_id_d    = req_id;
          greq_size_d  = req_size_m1;
        end
      end
    end

    if (gbar_req_valid && gbar_req_ready) begin
      greq_valid_d          = 1'b0;
      gstate_d[gbar_req_id] = G_SENT;
    end

    // Response uses the registered state, so a same-cycle handshake is not yet SENT.
    if (gbar_rsp_valid && gstate[gbar_rsp_id] == G_SENT) begin
      unlock_valid_d        = 1'b1;
      unlock_mask_d         = unlock_mask_d | gmask[gbar_rsp_id];
      gmask_d[gbar_rsp_id]  = '0;
      gstate_d[gbar_rsp_id] = G_IDLE;
    end

    stalled_d = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) stalled_d = stalled_d | lmask_d[b] | gmask_d[b];
  end

  // NOTE: the mask arrays are small flop banks, not RAM, and must be cleared so pending barriers are discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        lmask[b]  <= '0;
        gmask[b]  <= '0;
        gstate[b] <= G_IDLE;
      end
      gbar_req_valid   <= 1'b0;
      gbar_req_id      <= '0;
      gbar_req_size_m1 <= '0;
      stalled_warps    <= '0;
      unlock_valid     <= 1'b0;
      unlock_mask      <= '0;
      dup_err          <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      lmask            <= lmask_d;
      gmask            <= gmask_d;
      gstate           <= gstate_d;
      gbar_req_valid   <= greq_valid_d;
      gbar_req_id      <= greq_id_d;
      gbar_req_size_m1 <= greq_size_d;
      stalled_warps    <= stalled_d;
      unlock_valid     <= unlock_valid_d;
      unlock_mask      <= unlock_mask_d;
      dup_err          <= dup_d;
    end
  end

endmodule

// File: doc/warp_barrier_unit.md
Name: warp_barrier_unit

Overview:
Scheduler-side consumer of the barrier control record (valid, id, is_global, size_m1, is_noop) emitted by the warp-control SFU. Tracks per-barrier arrival masks, stalls arriving warps and releases them when a local barrier completes. For global barriers it raises one core-level request to the cluster barrier network once all active local warps arrive, then releases those warps on the matching response.

Parameters:
NUM_WARPS, 4, warps per core
NUM_BARRIERS, 4, barrier IDs per core
NUM_CORES, 4, cores participating in global barriers
NW_WIDTH, clog2(NUM_WARPS) (min 1), warp id width
NB_WIDTH, clog2(NUM_BARRIERS) (min 1), barrier id width
SZ_WIDTH, max(NW_WIDTH, clog2(NUM_CORES)), size_m1 width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  barrier record valid
req_ready  out  1  unit can accept a record
req_wid  in  NW_WIDTH  issuing warp
req_id  in  NB_WIDTH  barrier id
req_is_global  in  1  global barrier
req_size_m1  in  SZ_WIDTH  participants minus one (warps if local, cores if global)
req_is_noop  in  1  no barrier action
active_warps  in  NUM_WARPS  currently active warps
stalled_warps  out  NUM_WARPS  warps held at any barrier (registered)
unlock_valid  out  1  release pulse
unlock_mask  out  NUM_WARPS  warps released this cycle
gbar_req_valid  out  1  core-level global barrier request
gbar_req_id  out  NB_WIDTH  global barrier id
gbar_req_size_m1  out  SZ_WIDTH  cores minus one
gbar_req_ready  in  1  network accepts request
gbar_rsp_valid  in  1  global barrier completed
gbar_rsp_id  in  NB_WIDTH  completed barrier id
dup_err  out  1  one-cycle pulse: warp re-arrived at a barrier it already holds

Behaviour:
- Reset (async, any time, including mid-barrier): all local/global masks, gbar request regs, stalled_warps, unlock_valid, unlock_mask, dup_err cleared to 0. Pending barriers are discarded.
- State per id b: lmask[b], gmask[b] (NUM_WARPS each), gsent[b] (1 bit). Per-id gbar FSM: IDLE -> COLLECT (first global arrival) -> SENT (request handshaken) -> IDLE (gbar_rsp_valid for b).
- req_ready = !gbar_req_valid. Accept = req_valid & req_ready.
- is_noop accept: no state change, no unlock.
- Local accept, warp bit already set in lmask[id] or gmask[id]: dup_err=1 next cycle, state unchanged.
- Local accept, popcount(lmask[id]) == req_size_m1: next cycle unlock_valid=1, unlock_mask = lmask[id] | onehot(wid), lmask[id] cleared. size_m1=0 releases the issuing warp alone, 1-cycle latency.
- Local accept otherwise: lmask[id] |= onehot(wid). No unlock.
- Global accept: gmask[id] |= onehot(wid). If (gmask_new & active_warps) == active_warps: load gbar_req_id=id, gbar_req_size_m1=req_size_m1, gbar_req_valid=1 next cycle. Held stable until gbar_req_valid & gbar_req_ready, then cleared and gsent[id]=1.
- gbar_rsp_valid with gsent[rsp_id]: next cycle unlock_mask |= gmask[rsp_id], unlock_valid=1, gmask and gsent for that id cleared. Response for a non-SENT id: ignored.
- Local completion and global response in the same cycle: merged into one unlock pulse (OR of masks; masks are disjoint since a stalled warp cannot issue).
- unlock_valid / dup_err are single-cycle pulses; 0 when no event.
- stalled_warps = registered OR of all lmask and gmask, updated the cycle after any change; a released warp's bit falls the same cycle unlock_valid rises.
- All popcount and compare logic is combinational on registered masks; one record per cycle maximum.

Test Plan:
- size_m1=2, id=1, warps 0,2,3 arrive on consecutive cycles -> stalled_warps 0001, 0101, then unlock_valid=1 with unlock_mask=1101 and stalled_warps=0000.
- size_m1=0, warp 3 local -> unlock_mask=1000 next cycle, no stall.
- Warp 1 arrives at id 0 twice -> dup_err pulse on second, lmask stays 0010, no release.
- active_warps=0011, global id 2 from warps 0,1 -> gbar_req_valid with id=2; hold gbar_req_ready=0 for 3 cycles (req_ready=0, outputs stable); then ready -> later gbar_rsp_valid id=2 -> unlock_mask=0011.
- Local completion id 0 (mask 0100) and gbar_rsp id 3 (mask 0011) in the same cycle -> single unlock_mask=0111.
- Reset asserted with lmask[1]=0110 -> stalled_warps=0 immediately; subsequent arrivals start fresh counts.
